// File: rtl/input_conditioner_if.sv
// Pushbutton conditioner bus: raw pad inputs and repeat enables in, debounced level and event pulses out.
interface input_conditioner_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] raw_in;
    logic [CHANNELS-1:0] repeat_en;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] press;
    // "release" is a reserved word in SystemVerilog
    logic [CHANNELS-1:0] release_pulse;
    logic [CHANNELS-1:0] strobe;

    modport master (
        output raw_in, repeat_en,
        input  level, press, release_pulse, strobe
    );

    modport slave (
        input  raw_in, repeat_en,
        output level, press, release_pulse, strobe
    );
endinterface

// File: rtl/input_conditioner.sv
// Per-channel pushbutton conditioning: polarity, synchroniser, tick debouncer,
// press/release pulses and an auto-repeat strobe for held keys.
//
// state | meaning
// IDLE  | key up, or held with repeat disabled
// DELAY | held, waiting REPEAT_DELAY ticks for the first repeat
// RATE  | held, repeating every REPEAT_RATE ticks
module input_conditioner #(
    parameter int                  CHANNELS       = 4,
    parameter int                  SYNC_STAGES    = 2,
    parameter logic [CHANNELS-1:0] INVERT_MASK    = '1,
    parameter int                  PRESCALE       = 250,
    parameter int                  DEBOUNCE_TICKS = 200,
    parameter int                  REPEAT_DELAY   = 40000,
    parameter int                  REPEAT_RATE    = 8000
) (
    input logic                 clk,
    input logic                 reset,
    input_conditioner_if.slave  bus
);
    localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {IDLE, DELAY, RATE} rep_state_t;

    logic [PW-1:0]       pcnt;
    logic                tick;
    logic [CHANNELS-1:0] level_v, press_v, release_v, strobe_v;

    assign tick = (pcnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (reset)     pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + PW'(1);
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic [DW-1:0]          dcnt;
        logic                   level_q, press_q, release_q, strobe_q, strobe_d;
        logic                   flip, rise;
        logic [RW-1:0]          rcnt_q, rcnt_d;
        rep_state_t             state_q, state_d;

        always_ff @(posedge clk) begin
            if (reset) sync_q <= '0;
            else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.raw_in[g] ^ INVERT_MASK[g]};
        end
        assign s = sync_q[SYNC_STAGES-1];

        // flip is the cycle the debounced level takes the synchronised value
        assign flip = (s != level_q) && tick && (dcnt == DW'(DEBOUNCE_TICKS - 1));
        assign rise = flip & s;

        always_ff @(posedge clk) begin
            if (reset) begin
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                dcnt      <= '0;
            end else begin
                press_q   <= flip & s;
                release_q <= flip & ~s;
                if (s == level_q) begin
                    dcnt <= '0;
                end else if (flip) begin
                    level_q <= s;
                    dcnt    <= '0;
                end else if (tick) begin
                    dcnt <= dcnt + DW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q  <= IDLE;
                rcnt_q   <= '0;
                strobe_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                rcnt_q   <= rcnt_d;
                strobe_q <= strobe_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:    if (rise && bus.repeat_en[g]) state_d = DELAY;
                DELAY: begin
                    if (!level_q || !bus.repeat_en[g])
                        state_d = IDLE;
                    else if (tick && rcnt_q == RW'(REPEAT_DELAY - 1))
                        state_d = RATE;
                end
                RATE:    if (!level_q || !bus.repeat_en[g]) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // strobe is registered so the press strobe lines up with press/level
        always_comb begin
            strobe_d = 1'b0;
            rcnt_d   = rcnt_q;
            case (state_q)
                IDLE: begin
                    strobe_d = rise;
                    rcnt_d   = '0;
                end
                DELAY: begin
                    if (!level_q || !bus.repeat_en[g]) begin
                        rcnt_d = '0;
                    end else if (tick) begin
                        if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
                            strobe_d = 1'b1;
                            rcnt_d   = '0;
                        end else begin
                            rcnt_d = rcnt_q + RW'(1);
                        end
                    end
                end
                RATE: begin
                    if (!level_q || !bus.repeat_en[g]) begin
                        rcnt_d = '0;
                    end else if (tick) begin
                        if (rcnt_q == RW'(REPEAT_RATE - 1)) begin
                            strobe_d = 1'b1;
                            rcnt_d   = '0;
                        end else begin
                            rcnt_d = rcnt_q + RW'(1);
                        end
                    end
                end
                default: rcnt_d = '0;
            endcase
        end

        assign level_v[g]   = level_q;
        assign press_v[g]   = press_q;
        assign release_v[g] = release_q;
        assign strobe_v[g]  = strobe_q;
    end

    assign bus.level         = level_v;
    assign bus.press         = press_v;
    assign bus.release_pulse = release_v;
    assign bus.strobe        = strobe_v;
endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed table, multi-cycle corner
// sequences, and randomized traffic against a time-based reference model.
module tb_input_conditioner;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    input_conditioner_if #(.CHANNELS(4)) ifa ();
    input_conditioner_if #(.CHANNELS(4)) ifb ();

    input_conditioner #(
        .CHANNELS(4), .SYNC_STAGES(SS), .INVERT_MASK(4'b0000), .PRESCALE(1),
        .DEBOUNCE_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) u_a (.clk(clk), .reset(reset), .bus(ifa));

    input_conditioner #(
        .CHANNELS(4), .SYNC_STAGES(SS), .INVERT_MASK(4'b1111), .PRESCALE(3),
        .DEBOUNCE_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) u_b (.clk(clk), .reset(reset), .bus(ifb));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int ch;
        int high;
        bit ren;
        int exp_press;
        int exp_release;
        int exp_strobes;
    } vec_t;

    vec_t vecs[5];

    // reference model state (PRESCALE=1: one tick per cycle)
    bit [SS-1:0] m_sh [4];
    bit [3:0]    m_lvl, m_press, m_rel, m_str;
    int          m_dis [4];
    bit          m_act [4];
    int          m_t   [4];

    task automatic model_step(input bit rst, input bit [3:0] raw, input bit [3:0] ren);
        bit s, cur, rise, fall, st;
        for (int c = 0; c < 4; c++) begin
            if (rst) begin
                m_sh[c] = '0; m_lvl[c] = 0; m_press[c] = 0; m_rel[c] = 0;
                m_str[c] = 0; m_dis[c] = 0; m_act[c] = 0; m_t[c] = 0;
                continue;
            end
            s = m_sh[c][SS-1];
            m_sh[c] = {m_sh[c][SS-2:0], raw[c]};
            cur = m_lvl[c];
            rise = 0; fall = 0; st = 0;
            if (s == cur) m_dis[c] = 0;
            else if (m_dis[c] == DB - 1) begin
                m_lvl[c] = s; rise = s; fall = !s; m_dis[c] = 0;
            end else m_dis[c]++;
            if (m_act[c]) begin
                if (!cur || !ren[c]) m_act[c] = 0;
                else begin
                    m_t[c]++;
                    if (m_t[c] == RD || (m_t[c] > RD && (m_t[c] - RD) % RR == 0)) st = 1;
                end
            end else if (rise) begin
                st = 1; m_act[c] = ren[c]; m_t[c] = 0;
            end
            m_press[c] = rise; m_rel[c] = fall; m_str[c] = st;
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    initial begin
        int fp, fr, ns, other, acc;
        bit [3:0] rraw, rren;
        bit rrst;

        vecs[0] = '{ch: 0, high: 20, ren: 0, exp_press: 6,  exp_release: 26, exp_strobes: 1};
        vecs[1] = '{ch: 1, high: 3,  ren: 0, exp_press: -1, exp_release: -1, exp_strobes: 0};
        vecs[2] = '{ch: 1, high: 4,  ren: 0, exp_press: 6,  exp_release: 10, exp_strobes: 1};
        vecs[3] = '{ch: 2, high: 30, ren: 1, exp_press: 6,  exp_release: 36, exp_strobes: 8};
        vecs[4] = '{ch: 3, high: 2,  ren: 1, exp_press: -1, exp_release: -1, exp_strobes: 0};

        reset = 1'b1;
        ifa.raw_in = 4'h0; ifa.repeat_en = 4'h0;
        ifb.raw_in = 4'hF; ifb.repeat_en = 4'h0;
        repeat (3) cyc();
        chk("reset_level",   int'(ifa.level), 0);
        chk("reset_press",   int'(ifa.press), 0);
        chk("reset_release", int'(ifa.release_pulse), 0);
        chk("reset_strobe",  int'(ifa.strobe), 0);
        reset = 1'b0;

        // directed table: single pulse per record, measured relative to raw rise
        for (int i = 0; i < 5; i++) begin
            fp = -1; fr = -1; ns = 0; other = 0;
            ifa.repeat_en = vecs[i].ren ? 4'(1 << vecs[i].ch) : 4'h0;
            ifa.raw_in[vecs[i].ch] = 1'b1;
            for (int k = 1; k <= vecs[i].high + 14; k++) begin
                cyc();
                if (ifa.press[vecs[i].ch] && fp < 0) fp = k;
                if (ifa.release_pulse[vecs[i].ch] && fr < 0) fr = k;
                ns += int'(ifa.strobe[vecs[i].ch]);
                other |= int'(ifa.press | ifa.strobe) & ~(1 << vecs[i].ch);
                if (k == vecs[i].high) ifa.raw_in[vecs[i].ch] = 1'b0;
            end
            chk($sformatf("vec%0d_press_at", i),   fp, vecs[i].exp_press);
            chk($sformatf("vec%0d_release_at", i), fr, vecs[i].exp_release);
            chk($sformatf("vec%0d_strobes", i),    ns, vecs[i].exp_strobes);
            chk($sformatf("vec%0d_other_ch", i),   other, 0);
        end
        ifa.repeat_en = 4'h0;

        // repeat_en dropped between strobes: repeats stop, level holds
        ns = 0;
        ifa.repeat_en[2] = 1'b1;
        ifa.raw_in[2] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            ns += int'(ifa.strobe[2]);
            if (k == 17) ifa.repeat_en[2] = 1'b0;
        end
        chk("ren_drop_strobes", ns, 2);
        chk("ren_drop_level", int'(ifa.level[2]), 1);
        ifa.raw_in[2] = 1'b0;
        repeat (14) cyc();

        // inverted pads with PRESCALE=3
        acc = 0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            acc |= int'(ifb.level | ifb.press | ifb.release_pulse | ifb.strobe);
        end
        chk("inv_idle_outputs", acc, 0);
        fp = -1; other = 0;
        ifb.raw_in[0] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (ifb.press[0] && fp < 0) fp = k;
            other |= int'(ifb.press[3:1]);
        end
        chk("inv_press_window", int'(fp >= 12 && fp <= 16), 1);
        chk("inv_other_press", other, 0);
        chk("inv_level0", int'(ifb.level[0]), 1);

        // reset while held: no release, fresh press after normal latency
        ifa.raw_in[3] = 1'b1;
        repeat (10) cyc();
        chk("pre_reset_level3", int'(ifa.level[3]), 1);
        reset = 1'b1;
        cyc();
        chk("midreset_outputs",
            int'({ifa.level, ifa.press, ifa.release_pulse, ifa.strobe}), 0);
        reset = 1'b0;
        fp = -1; fr = -1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (ifa.press[3] && fp < 0) fp = k;
            if (ifa.release_pulse != 4'h0 && fr < 0) fr = k;
        end
        chk("post_reset_press_at", fp, 6);
        chk("post_reset_release", fr, -1);
        ifa.raw_in = 4'h0;
        repeat (14) cyc();

        // randomized traffic vs reference model
        reset = 1'b1;
        rraw = 4'h0; rren = 4'h0;
        ifa.raw_in = rraw; ifa.repeat_en = rren;
        @(posedge clk);
        model_step(1'b1, rraw, rren);
        #1;
        for (int n = 0; n < 3000; n++) begin
            rrst = ($urandom_range(0, 499) == 0);
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 11) == 0) rraw[c] = ~rraw[c];
                if ($urandom_range(0, 39) == 0) rren[c] = ~rren[c];
            end
            reset = rrst;
            ifa.raw_in = rraw;
            ifa.repeat_en = rren;
            @(posedge clk);
            model_step(rrst, rraw, rren);
            #1;
            chk($sformatf("rnd%0d_level", n),   int'(ifa.level),         int'(m_lvl));
            chk($sformatf("rnd%0d_press", n),   int'(ifa.press),         int'(m_press));
            chk($sformatf("rnd%0d_release", n), int'(ifa.release_pulse), int'(m_rel));
            chk($sformatf("rnd%0d_strobe", n),  int'(ifa.strobe),        int'(m_str));
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
